// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and elaboration helpers for the mux_scan_serializer slice.
// Holds the FSM state encoding and the minimum select width for a given word width.
package mux_scan_serializer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Narrowest select width able to address n mux inputs (at least one bit).
  function automatic int unsigned idx_width_min(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_serializer_if.sv
// Word-in / bit-out handshake bundle for mux_scan_serializer.
// The slave modport is the serializer's view; master is the environment's view.
interface mux_scan_serializer_if #(
  parameter int unsigned N = 9,
  parameter int unsigned M = 4
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_bit;
  logic [M-1:0] out_idx;
  logic         out_last;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_bit,
    output out_idx,
    output out_last
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_bit,
    input  out_idx,
    input  out_last
  );

endinterface

// File: rtl/mux_n.sv
// N-input, one-bit selector tree; select values at or beyond N yield 0.
module mux_n #(
  parameter int unsigned N = 2,
  parameter int unsigned m = 1
) (
  input  logic [N-1:0] inp,
  input  logic [m-1:0] select,
  output logic         out
);

  always_comb begin
    out = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (select == m'(i)) begin
        out = inp[i];
      end
    end
  end

endmodule

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end: captures a word, then walks mux_n's select across it,
// emitting one bit per accepted output beat.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int unsigned N         = 9,
  parameter int unsigned M         = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  mux_scan_serializer_if.slave bus
);

  if (N < 1 || M < idx_width_min(N)) begin : g_param_err
    $error("mux_scan_serializer: M is too narrow to index N inputs");
  end

  localparam logic [M-1:0] IdxHi    = M'(N - 1);
  localparam logic [M-1:0] IdxFirst = LSB_FIRST ? '0 : IdxHi;
  localparam logic [M-1:0] IdxTerm  = LSB_FIRST ? IdxHi : '0;

  state_e       state_q, state_d;
  logic [M-1:0] idx_q, idx_d;
  logic [N-1:0] data_q, data_d;

  logic in_ready;
  logic out_valid;
  logic out_last;
  logic out_bit;
  logic at_term;

  mux_n #(
    .N (N),
    .m (M)
  ) u_mux (
    .inp    (data_q),
    .select (idx_q),
    .out    (out_bit)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    // Hold off upstream while reset is asserted so no word is lost into a flushing FSM.
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StShift);
    at_term   = (idx_q == IdxTerm);
    out_last  = out_valid && at_term;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready) begin
          data_d  = bus.in_data;
          idx_d   = IdxFirst;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.out_ready) begin
          if (at_term) begin
            state_d = StIdle;
          end else if (LSB_FIRST) begin
            idx_d = idx_q + M'(1);
          end else begin
            idx_d = idx_q - M'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_bit;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = out_last;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: LSB-first, MSB-first and single-bit builds.
module tb_mux_scan_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_scan_serializer_if #(.N(9), .M(4)) bus_l ();
  mux_scan_serializer_if #(.N(9), .M(4)) bus_m ();
  mux_scan_serializer_if #(.N(1), .M(1)) bus_1 ();

  mux_scan_serializer #(.N(9), .M(4), .LSB_FIRST(1'b1)) u_dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  mux_scan_serializer #(.N(9), .M(4), .LSB_FIRST(1'b0)) u_dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  mux_scan_serializer #(.N(1), .M(1), .LSB_FIRST(1'b1)) u_dut_1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_1)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Feed one word to the LSB-first DUT and consume its nine beats against exp_q.
  task automatic run_l(input logic [8:0] word, input bit stall, input bit check_lat);
    int unsigned beats;
    int unsigned cycles;
    check_eq("l_cap_ready", 32'(bus_l.in_ready), 32'd1);
    bus_l.in_valid  = 1'b1;
    bus_l.in_data   = word;
    bus_l.out_ready = 1'b1;
    @(negedge clk);
    bus_l.in_valid = 1'b0;
    bus_l.in_data  = ~word;
    beats  = 0;
    cycles = 0;
    while (beats < 9 && cycles < 200) begin
      bus_l.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check_eq("l_valid", 32'(bus_l.out_valid), 32'd1);
      check_eq("l_in_ready_busy", 32'(bus_l.in_ready), 32'd0);
      check_eq("l_idx", 32'(bus_l.out_idx), beats);
      check_eq("l_bit", 32'(bus_l.out_bit), 32'(exp_q[beats]));
      check_eq("l_last", 32'(bus_l.out_last), 32'(beats == 8));
      if (bus_l.out_ready) beats++;
      cycles++;
      @(negedge clk);
    end
    check_eq("l_beat_count", beats, 32'd9);
    if (check_lat) check_eq("l_cycles_to_idle", cycles, 32'd9);
    check_eq("l_done_valid", 32'(bus_l.out_valid), 32'd0);
    check_eq("l_done_ready", 32'(bus_l.in_ready), 32'd1);
  endtask

  initial begin
    bus_l.in_valid = 1'b0; bus_l.in_data = '0; bus_l.out_ready = 1'b0;
    bus_m.in_valid = 1'b0; bus_m.in_data = '0; bus_m.out_ready = 1'b0;
    bus_1.in_valid = 1'b0; bus_1.in_data = '0; bus_1.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(bus_l.out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(bus_l.in_ready), 32'd0);
    check_eq("rst_idx", 32'(bus_l.out_idx), 32'd0);
    check_eq("rst_last", 32'(bus_l.out_last), 32'd0);
    check_eq("rst_bit", 32'(bus_l.out_bit), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(bus_l.in_ready), 32'd1);
    check_eq("post_rst_valid", 32'(bus_l.out_valid), 32'd0);
    check_eq("post_rst_m_ready", 32'(bus_m.in_ready), 32'd1);

    // LSB-first 9'h1A5
    exp_q = '{1, 0, 1, 0, 0, 1, 0, 1, 1};
    run_l(9'h1A5, 1'b0, 1'b1);

    // MSB-first 9'h1A5
    exp_q = '{1, 1, 0, 1, 0, 0, 1, 0, 1};
    bus_m.in_valid  = 1'b1;
    bus_m.in_data   = 9'h1A5;
    bus_m.out_ready = 1'b1;
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check_eq("m_valid", 32'(bus_m.out_valid), 32'd1);
      check_eq("m_idx", 32'(bus_m.out_idx), 32'(8 - k));
      check_eq("m_bit", 32'(bus_m.out_bit), 32'(exp_q[k]));
      check_eq("m_last", 32'(bus_m.out_last), 32'(k == 8));
      @(negedge clk);
    end
    check_eq("m_done_valid", 32'(bus_m.out_valid), 32'd0);
    check_eq("m_done_ready", 32'(bus_m.in_ready), 32'd1);

    // Backpressure on 9'h0F0
    exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    run_l(9'h0F0, 1'b1, 1'b0);

    // Continuous in_valid: 9'h001 then 9'h100 with a single idle bubble between them
    bus_l.in_valid  = 1'b1;
    bus_l.in_data   = 9'h001;
    bus_l.out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus_l.in_data = 9'h100;
      if (i == 19) bus_l.in_valid = 1'b0;
      check_eq("cont_valid", 32'(bus_l.out_valid), 32'(!(i == 10 || i == 20)));
      check_eq("cont_ready", 32'(bus_l.in_ready), 32'(i == 10 || i == 20));
      if (i < 10) begin
        check_eq("cont_bit_a", 32'(bus_l.out_bit), 32'(i == 1));
        check_eq("cont_idx_a", 32'(bus_l.out_idx), 32'(i - 1));
      end else if (i > 10 && i < 20) begin
        check_eq("cont_bit_b", 32'(bus_l.out_bit), 32'(i == 19));
        check_eq("cont_idx_b", 32'(bus_l.out_idx), 32'(i - 11));
      end
    end

    // Reset after the 4th beat of 9'h1FF
    bus_l.in_valid  = 1'b1;
    bus_l.in_data   = 9'h1FF;
    bus_l.out_ready = 1'b1;
    @(negedge clk);
    bus_l.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_idx_before_rst", 32'(bus_l.out_idx), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(bus_l.out_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(bus_l.in_ready), 32'd0);
    check_eq("mid_rst_idx", 32'(bus_l.out_idx), 32'd0);
    check_eq("mid_rst_bit", 32'(bus_l.out_bit), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_post_valid", 32'(bus_l.out_valid), 32'd0);
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_l(9'h000, 1'b0, 1'b1);

    // N=1, M=1
    bus_1.in_valid  = 1'b1;
    bus_1.in_data   = 1'b1;
    bus_1.out_ready = 1'b1;
    @(negedge clk);
    bus_1.in_valid = 1'b0;
    bus_1.in_data  = 1'b0;
    check_eq("n1_valid", 32'(bus_1.out_valid), 32'd1);
    check_eq("n1_bit", 32'(bus_1.out_bit), 32'd1);
    check_eq("n1_last", 32'(bus_1.out_last), 32'd1);
    check_eq("n1_idx", 32'(bus_1.out_idx), 32'd0);
    @(negedge clk);
    check_eq("n1_done_valid", 32'(bus_1.out_valid), 32'd0);
    check_eq("n1_done_ready", 32'(bus_1.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_serializer.md
# mux_scan_serializer

Parallel-to-serial front end for the `mux_n` selector tree. It accepts an N-bit word through a valid/ready handshake and holds it in a register that drives `mux_n.inp`. It then steps `mux_n.select` through 0..N-1, emitting one bit per accepted output beat. It sits directly upstream of `mux_n`, owning its select sequencing, and presents the muxed bit downstream with its own valid/ready handshake.

## Interface
- `N`, 9: word width and number of mux inputs; N ≥ 1.
- `M`, 4: select/index width; must satisfy 2^M ≥ N and M ≥ 1.
- `LSB_FIRST`, 1: 1 = emit index 0 first, ascending; 0 = emit index N-1 first, descending.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  N  parallel word.
- `out_valid`  out  1  `out_bit` valid.
- `out_ready`  in  1  downstream accepts the current bit.
- `out_bit`  out  1  `mux_n` output for the current index.
- `out_idx`  out  M  current select value driven into `mux_n`.
- `out_last`  out  1  current beat is the final bit of the word.

## Operation
- Two states: IDLE and SHIFT.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid & in_ready`: capture `in_data` into `data_q`; load `idx_q` with 0 (LSB_FIRST=1) or N-1 (LSB_FIRST=0); go to SHIFT.
- SHIFT:
  - `in_ready`=0, `out_valid`=1.
  - `out_bit` = `data_q[idx_q]`, computed by the `mux_n` instance with `select=idx_q`.
  - `out_idx`=`idx_q`.
  - `out_last` = (`idx_q`==N-1) when LSB_FIRST=1, (`idx_q`==0) when LSB_FIRST=0.
- Beat accepted (`out_valid & out_ready`):
  - If `out_last`: go to IDLE.
  - Otherwise step `idx_q` by ±1.
- No beat (`out_ready`=0): `data_q`, `idx_q`, `out_bit` and `out_idx` hold unchanged.
- `in_data` changes are ignored outside the capture cycle.
- Index arithmetic is M-bit unsigned. It never wraps, because the terminal value triggers the return to IDLE before any step past it.
- N=1: SHIFT lasts exactly one accepted beat with `out_last`=1 and `out_idx`=0.
- Reset values while `rst`=1 and on the first cycle after: state IDLE, `idx_q`=0, `data_q`=0, `out_valid`=0, `out_last`=0, `out_idx`=0, `out_bit`=0. `in_ready`=0 while `rst` is high and 1 on the first cycle after release.
- Reset mid-word: the partial word is discarded. No further beats are emitted and no completion is signalled.

## Timing
- Capture to first bit: `out_valid` rises in the cycle after the `in_valid & in_ready` edge, i.e. 1-cycle latency.
- `out_bit` and `out_last` are combinational from registered `data_q`/`idx_q` through `mux_n`. There is no combinational path from `in_*` or `out_ready` to any output.
- Throughput: N beats per word plus one IDLE bubble, so N+1 cycles per word minimum with `out_ready` held high.
- `in_ready` depends only on state, never on `in_valid`. Upstream may hold `in_valid` high continuously.
- `out_valid` never drops once high until the last beat is accepted (AXI-style stability). `out_bit`/`out_idx` are stable while `out_valid & !out_ready`.

## Structure
- Shared package: state enum (IDLE, SHIFT). Also a `clog2`-based helper constant used to check 2^M ≥ N with an elaboration-time assertion.
- One sub-module: the existing `mux_n` (parameters N, m=M) instantiated once; `inp`=`data_q`, `select`=`idx_q`.
- The FSM, index counter and data register live in this module.

## Test plan
- Reset, N=9, LSB_FIRST=1:
  - Load 9'h1A5 with `out_ready`=1 → `out_bit` sequence 1,0,1,0,0,1,0,1,1.
  - `out_idx` runs 0..8; `out_last` only at idx 8.
  - `in_ready` is 1 again exactly 10 cycles after capture.
- LSB_FIRST=0, load 9'h1A5 → bits 1,1,0,1,0,0,1,0,1 with `out_idx` 8..0; `out_last` at idx 0.
- Backpressure: load 9'h0F0 and toggle `out_ready` at random → no bit lost or duplicated. `out_bit`/`out_idx` hold during stalls. 9 accepted beats total.
- Continuous `in_valid` with words 9'h001 then 9'h100 → second capture occurs only in IDLE, one bubble between words. Streams are 1,0×8 then 0×8,1.
- Assert `rst` after the 4th beat of 9'h1FF → next cycle `out_valid`=0, `in_ready`=0. After release, a new load of 9'h000 streams nine zeros from idx 0.
- N=1, M=1: load 1'b1 → a single beat with `out_bit`=1, `out_last`=1, `out_idx`=0, then IDLE.
